// File: rtl/piso_pkg.sv
// Shared definitions for the piso_tx serial transmitter.
//   state_t      : transmitter FSM states
//   SO_IDLE      : level of the serial line when no frame is in progress
//   frame_clks() : clocks from the falling edge of the start bit to the end of
//                  the stop bit, for a given word width, bit period and parity
package piso_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic SO_IDLE = 1'b1;

  function automatic int frame_clks(input int width, input int clks_per_bit,
                                    input int parity_en);
    return (2 + width + parity_en) * clks_per_bit;
  endfunction

endpackage

// File: rtl/piso_tx_if.sv
// Handshake and serial-output bundle of the piso_tx transmitter.
//   pi       : parallel word offered to the transmitter
//   pi_valid : pi holds a word to send
//   pi_ready : transmitter accepts a word this cycle
//   so       : serial line, idles high
//   busy     : a frame is in progress
//   done     : one-cycle pulse after the stop bit ends
// master = word source, slave = transmitter.
interface piso_tx_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] pi;
  logic             pi_valid;
  logic             pi_ready;
  logic             so;
  logic             busy;
  logic             done;

  modport master (
    output pi, pi_valid,
    input  pi_ready, so, busy, done
  );

  modport slave (
    input  pi, pi_valid,
    output pi_ready, so, busy, done
  );

endinterface

// File: rtl/piso_tx_bit_timer.sv
// Bit-period timer for piso_tx.
//   clk      : clock
//   rst      : asynchronous active-low reset
//   start    : reload the counter (a new frame is being accepted)
//   en       : a frame is in progress; the counter runs
//   bit_tick : high in the last clock of every bit period
// Counts CLKS_PER_BIT-1 down to 0 and reloads, so every bit, including the
// first after start, lasts exactly CLKS_PER_BIT clocks.
module piso_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic en,
  output logic bit_tick
);

  // CLKS_PER_BIT = 1 still needs a one-bit counter that simply stays at 0.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_tick = en && (cnt == '0);

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values, independent of the order of the always blocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (start || bit_tick) begin
      cnt <= RELOAD;
    end else if (en) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in / serial-out transmitter.
//   clk : clock
//   rst : asynchronous active-low reset; aborts any frame in progress
//   bus : piso_tx_if slave port (pi, pi_valid in; pi_ready, so, busy, done out)
// A word accepted on pi_valid & pi_ready is sent as: start bit (0), data LSB
// first, optional even-parity bit, stop bit (1). Each bit lasts CLKS_PER_BIT
// clocks. All outputs are flops loaded from the next-state decode, so they
// change on the same edge as the FSM state.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic           clk,
  input  logic           rst,
  piso_tx_if.slave       bus
);

  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  state_t           state;
  state_t           nxt_state;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_nxt;
  logic [BIT_W-1:0] bit_cnt;
  logic [BIT_W-1:0] bit_cnt_nxt;
  logic             parity_q;
  logic             so_nxt;
  logic             accept;
  logic             bit_tick;

  // pi_ready is itself a flop that is only high in IDLE, so a word is
  // accepted only after the transmitter has advertised it can take one.
  assign accept = (state == IDLE) && bus.pi_ready && bus.pi_valid;

  piso_tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (accept),
    .en       (state != IDLE),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nxt_state;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    nxt_state   = state;
    shift_nxt   = shift_q;
    bit_cnt_nxt = bit_cnt;

    case (state)
      IDLE: begin
        if (accept) begin
          nxt_state   = START;
          shift_nxt   = bus.pi;
          bit_cnt_nxt = '0;
        end
      end
      START: begin
        if (bit_tick) nxt_state = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift_nxt = shift_q >> 1;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_nxt = '0;
            nxt_state   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_tick) nxt_state = STOP;
      end
      STOP: begin
        if (bit_tick) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase

    // Line level for the state being entered; shift_nxt[0] is the data bit
    // that will be on the line after this edge.
    case (nxt_state)
      START:   so_nxt = 1'b0;
      DATA:    so_nxt = shift_nxt[0];
      PARITY:  so_nxt = parity_q;
      default: so_nxt = SO_IDLE;
    endcase
  end

  // NOTE: the shift register is a plain datapath register, not a memory
  // array, so it is cleared by reset along with the rest of the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q      <= '0;
      bit_cnt      <= '0;
      parity_q     <= 1'b0;
      bus.so       <= SO_IDLE;
      bus.pi_ready <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      shift_q      <= shift_nxt;
      bit_cnt      <= bit_cnt_nxt;
      if (accept) parity_q <= ^bus.pi;
      bus.so       <= so_nxt;
      bus.pi_ready <= (nxt_state == IDLE);
      bus.busy     <= (nxt_state != IDLE);
      bus.done     <= (state == STOP) && (nxt_state == IDLE);
    end
  end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in/serial-out transmitter that sits at the far end of the block's parallel data registers. It accepts a parallel word through a valid/ready handshake and emits it on a single wire as a framed serial stream: start bit, data LSB first, optional even parity, stop bit. Each bit is held for a programmable number of clocks. It is the serialising counterpart to the team's parallel capture registers.

## Interface
- WIDTH, 4, data word width in bits, at least 1
- CLKS_PER_BIT, 4, clocks per serial bit, at least 1
- PARITY_EN, 1, 1 inserts an even-parity bit after the data bits; 0 omits it
- clk  input  1  rising-edge clock; the block's only clock
- rst  input  1  reset, asynchronous, active-low; asserting it clears all state immediately
- pi  input  WIDTH  parallel word, sampled only on the handshake cycle
- pi_valid  input  1  word on pi is offered
- pi_ready  output  1  transmitter can accept a word this cycle
- so  output  1  serial line; idles high
- busy  output  1  a frame is in progress
- done  output  1  one-cycle pulse after the stop bit ends

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: so=1, pi_ready=1, busy=0.
  - On pi_valid & pi_ready, load pi into the shift register.
  - Compute parity = XOR of pi.
  - Clear the bit and clock counters, then go to START.
- START: so=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: so=shift[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit counter.
  - After WIDTH bits, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: so=parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP: so=1 for CLKS_PER_BIT cycles, then go to IDLE.
- done pulses high for one cycle on the first IDLE cycle after STOP.
- busy=1 in every state except IDLE.
- pi_ready=0 in every state except IDLE.
- pi and pi_valid are ignored outside the handshake cycle. Changing pi mid-frame does not affect the frame.
- pi_valid held high continuously gives back-to-back frames, separated by exactly one idle-high cycle.
- Reset asserted mid-frame aborts the frame.
  - On assertion: so=1, state=IDLE, counters=0, no done pulse.
- CLKS_PER_BIT=1 is legal: each bit lasts one clock.

## Timing
- All outputs are registered.
- Reset values: so=1, pi_ready=0, busy=0, done=0. pi_ready rises on the first clock edge after rst deasserts.
- Handshake at edge N: so falls at edge N+1; busy and pi_ready change at edge N+1.
- Frame length F = (2 + WIDTH + PARITY_EN) × CLKS_PER_BIT cycles, from so falling to the end of the stop bit.
- done is high during the cycle starting at edge N+1+F, with pi_ready=1 in the same cycle.
- A new handshake is possible at that same edge, N+1+F.
- Minimum accept-to-accept period is F+1 cycles.
- Clock counter width: $clog2(CLKS_PER_BIT), minimum 1 bit.
- Bit counter width: $clog2(WIDTH+1).
- The counter wraps to 0 on each bit boundary; counters never overflow.

## Structure
- Shared package piso_pkg holds:
  - the state enum: IDLE, START, DATA, PARITY, STOP
  - SO_IDLE=1'b1
  - the frame-length function frame_clks(WIDTH, CLKS_PER_BIT, PARITY_EN), shared with the bench.
- One natural sub-module, bit_timer: a CLKS_PER_BIT down-counter that emits a bit_tick strobe and reloads on start.
- FSM, shift register and parity logic stay in piso_tx.

## Test plan
All scenarios use WIDTH=4, CLKS_PER_BIT=4.
- Reset release, PARITY_EN=1, pi_valid=0 for 20 cycles: so=1, busy=0, done=0 throughout; pi_ready=1 from the first edge after release.
- PARITY_EN=1, pi=4'b1011 accepted at edge N:
  - so = 0,1,1,0,1,1,1 (start, data LSB first, parity=1, stop), each bit held 4 cycles
  - done pulses in the cycle after edge N+29.
- PARITY_EN=0, pi=4'b0110: so = 0,0,1,1,0,1 (24 cycles), done 25 cycles after the accept edge.
- pi_valid held high with pi=4'hF then 4'h0 (PARITY_EN=1):
  - second accept occurs exactly 29 cycles after the first
  - exactly one idle-high cycle between frames
  - second frame parity bit = 0.
- Mid-frame reset: assert rst=0 during the DATA bit 2 of pi=4'h5.
  - so=1 and busy=0 immediately, with no done pulse.
  - After release, a fresh accept of 4'hA produces a correct full frame.
- pi is changed every cycle during a frame of 4'h9: the serial data bits still read 1,0,0,1.
